row_access_sequencer: RTL and testbench

//  Parametrised, timed successor to the combinational row decoder. Accepts one row-access request per

---
 rtl/sram_ctrl_pkg.sv | 25 ++
 rtl/row_predecoder_n.sv | 44 ++++
 rtl/row_access_sequencer.sv | 134 +++++++++++++
 tb/tb_row_access_sequencer.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_ctrl_pkg.sv
// ============================================================================
// sram_ctrl_pkg : shared state encoding and default timing for SRAM row access
// Rev 1.0
// ============================================================================
`default_nettype none

package sram_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRE   = 3'd1,
    ST_WL    = 3'd2,
    ST_SENSE = 3'd3,
    ST_REC   = 3'd4
  } state_t;

  localparam int DEF_ADDR_WIDTH = 6;
  localparam int DEF_PRE_CYCLES = 1;
  localparam int DEF_WL_CYCLES  = 2;
  localparam int DEF_REC_CYCLES = 1;
  localparam int DEF_CNT_W      = 4;

endpackage

`default_nettype wire

// File: rtl/row_predecoder_n.sv
// ============================================================================
// row_predecoder_n : two-level predecoded row decoder (low/high one-hot + AND)
// Rev 1.0
// ============================================================================
`default_nettype none

module row_predecoder_n #(
  parameter int ADDR_WIDTH = 6,
  localparam int NUM_ROWS  = 2**ADDR_WIDTH
) (
  input  logic                  en,
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [NUM_ROWS-1:0]   rows
);

  localparam int LO_W    = ADDR_WIDTH / 2;
  localparam int HI_W    = ADDR_WIDTH - LO_W;
  localparam int LO_ROWS = 2**LO_W;
  localparam int HI_ROWS = 2**HI_W;

  logic [LO_ROWS-1:0] w_lo_dec;
  logic [HI_ROWS-1:0] w_hi_dec;

  // Both predecoders gated by en so a disabled decoder yields all-zero rows.
  always_comb begin
    w_lo_dec = '0;
    w_hi_dec = '0;
    if (en) begin
      w_lo_dec[addr[LO_W-1:0]]          = 1'b1;
      w_hi_dec[addr[ADDR_WIDTH-1:LO_W]] = 1'b1;
    end
  end

  generate
    for (genvar h = 0; h < HI_ROWS; h++) begin : g_hi
      for (genvar l = 0; l < LO_ROWS; l++) begin : g_lo
        assign rows[h*LO_ROWS + l] = w_hi_dec[h] & w_lo_dec[l];
      end
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/row_access_sequencer.sv
// ============================================================================
// row_access_sequencer : timed precharge / wordline / sense-or-write / recovery
// Rev 1.0
// ============================================================================
`default_nettype none

module row_access_sequencer
  import sram_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int PRE_CYCLES = DEF_PRE_CYCLES,
  parameter int WL_CYCLES  = DEF_WL_CYCLES,
  parameter int REC_CYCLES = DEF_REC_CYCLES,
  parameter int CNT_W      = DEF_CNT_W,
  localparam int NUM_ROWS  = 2**ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic                  req_we,
  output logic                  precharge_en,
  output logic [NUM_ROWS-1:0]   wl_en,
  output logic                  write_en,
  output logic                  sense_en,
  output logic                  done,
  output logic                  busy
);

  localparam logic [CNT_W-1:0] PRE_LOAD = CNT_W'(PRE_CYCLES - 1);
  localparam logic [CNT_W-1:0] WL_LOAD  = CNT_W'(WL_CYCLES - 1);
  localparam logic [CNT_W-1:0] REC_LOAD = CNT_W'(REC_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t                r_state;
  state_t                w_nxt_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [CNT_W-1:0]      w_nxt_cnt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_we;
  logic                  w_accept;
  logic [NUM_ROWS-1:0]   w_rows;

  assign w_accept = (r_state == ST_IDLE) && req_valid;

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_cnt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (req_valid) begin
          w_nxt_state = ST_PRE;
          w_nxt_cnt   = PRE_LOAD;
        end
      end
      ST_PRE: begin
        if (r_cnt == '0) begin
          w_nxt_state = ST_WL;
          w_nxt_cnt   = WL_LOAD;
        end else begin
          w_nxt_cnt   = r_cnt - CNT_ONE;
        end
      end
      ST_WL: begin
        if (r_cnt == '0) begin
          w_nxt_state = r_we ? ST_REC : ST_SENSE;
          w_nxt_cnt   = r_we ? REC_LOAD : '0;
        end else begin
          w_nxt_cnt   = r_cnt - CNT_ONE;
        end
      end
      ST_SENSE: begin
        w_nxt_state = ST_REC;
        w_nxt_cnt   = REC_LOAD;
      end
      ST_REC: begin
        if (r_cnt == '0) begin
          w_nxt_state = ST_IDLE;
          w_nxt_cnt   = '0;
        end else begin
          w_nxt_cnt   = r_cnt - CNT_ONE;
        end
      end
      default: begin
        w_nxt_state = ST_IDLE;
        w_nxt_cnt   = '0;
      end
    endcase
  end

  // The address is latched at accept, at least one PRE cycle before decode uses it.
  row_predecoder_n #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_predec (
    .en  (w_nxt_state == ST_WL),
    .addr(r_addr),
    .rows(w_rows)
  );

  // Outputs are decoded from the next state and registered, so wl_en is glitch-free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_addr       <= '0;
      r_we         <= 1'b0;
      req_ready    <= 1'b1;
      busy         <= 1'b0;
      precharge_en <= 1'b0;
      wl_en        <= '0;
      write_en     <= 1'b0;
      sense_en     <= 1'b0;
      done         <= 1'b0;
    end else begin
      r_state <= w_nxt_state;
      r_cnt   <= w_nxt_cnt;
      if (w_accept) begin
        r_addr <= req_addr;
        r_we   <= req_we;
      end
      req_ready    <= (w_nxt_state == ST_IDLE);
      busy         <= (w_nxt_state != ST_IDLE);
      precharge_en <= (w_nxt_state == ST_PRE);
      wl_en        <= w_rows;
      write_en     <= (w_nxt_state == ST_WL) && r_we;
      sense_en     <= (w_nxt_state == ST_SENSE);
      done         <= (w_nxt_state == ST_REC) && (w_nxt_cnt == '0);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_row_access_sequencer.sv
// ============================================================================
// tb_row_access_sequencer : scoreboard bench, default and wide/slow instances
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_row_access_sequencer;

  typedef struct packed {
    logic         ready;
    logic         busy;
    logic         pre;
    logic         wen;
    logic         se;
    logic         done;
    logic [127:0] wl;
  } exp_t;

  localparam exp_t IDLE_R = '{ready: 1'b1, busy: 1'b0, pre: 1'b0, wen: 1'b0,
                              se: 1'b0, done: 1'b0, wl: '0};
  localparam exp_t BUSY_R = '{ready: 1'b0, busy: 1'b1, pre: 1'b0, wen: 1'b0,
                              se: 1'b0, done: 1'b0, wl: '0};

  logic         clk = 1'b0;
  logic         rst_n [2];
  logic         valid [2];
  logic [6:0]   addr  [2];
  logic         we    [2];
  logic         rdy   [2];
  logic         pre   [2];
  logic         wen   [2];
  logic         se    [2];
  logic         dn    [2];
  logic         bsy   [2];
  logic [63:0]  wl0;
  logic [127:0] wl1;

  exp_t q0[$];
  exp_t q1[$];
  int   busy_left [2];
  int   acc_cnt   [2];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  row_access_sequencer #(
    .ADDR_WIDTH(6), .PRE_CYCLES(1), .WL_CYCLES(2), .REC_CYCLES(1), .CNT_W(4)
  ) u_dut0 (
    .clk(clk), .rst_n(rst_n[0]), .req_valid(valid[0]), .req_ready(rdy[0]),
    .req_addr(addr[0][5:0]), .req_we(we[0]), .precharge_en(pre[0]), .wl_en(wl0),
    .write_en(wen[0]), .sense_en(se[0]), .done(dn[0]), .busy(bsy[0])
  );

  row_access_sequencer #(
    .ADDR_WIDTH(7), .PRE_CYCLES(2), .WL_CYCLES(3), .REC_CYCLES(2), .CNT_W(4)
  ) u_dut1 (
    .clk(clk), .rst_n(rst_n[1]), .req_valid(valid[1]), .req_ready(rdy[1]),
    .req_addr(addr[1]), .req_we(we[1]), .precharge_en(pre[1]), .wl_en(wl1),
    .write_en(wen[1]), .sense_en(se[1]), .done(dn[1]), .busy(bsy[1])
  );

  function automatic exp_t actual(input int d);
    exp_t a;
    a.ready = rdy[d];
    a.busy  = bsy[d];
    a.pre   = pre[d];
    a.wen   = wen[d];
    a.se    = se[d];
    a.done  = dn[d];
    a.wl    = (d == 0) ? {64'b0, wl0} : wl1;
    return a;
  endfunction

  function automatic void put(input int d, input exp_t e);
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endfunction

  // Reference: one record per clock of the access, straight from the phase rules.
  function automatic void push_access(input int d, input logic [6:0] ad, input logic w);
    int   np  = (d == 0) ? 1 : 2;
    int   nw  = (d == 0) ? 2 : 3;
    int   nr  = (d == 0) ? 1 : 2;
    int   tot = 0;
    exp_t e;
    for (int i = 0; i < np; i++) begin
      e = BUSY_R; e.pre = 1'b1; put(d, e); tot++;
    end
    for (int i = 0; i < nw; i++) begin
      e = BUSY_R; e.wl = 128'd1 << ad; e.wen = w; put(d, e); tot++;
    end
    if (!w) begin
      e = BUSY_R; e.se = 1'b1; put(d, e); tot++;
    end
    for (int i = 0; i < nr; i++) begin
      e = BUSY_R; e.done = (i == nr - 1); put(d, e); tot++;
    end
    busy_left[d] = tot;
  endfunction

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst_n[d]) begin
        if (d == 0) q0.delete();
        else        q1.delete();
        busy_left[d] = 0;
      end else if (busy_left[d] > 0) begin
        busy_left[d]--;
      end else if (valid[d]) begin
        push_access(d, addr[d], we[d]);
        acc_cnt[d]++;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    for (int d = 0; d < 2; d++) begin
      exp_t e;
      exp_t a;
      e = IDLE_R;
      if (d == 0) begin
        if (q0.size() > 0) e = q0.pop_front();
      end else begin
        if (q1.size() > 0) e = q1.pop_front();
      end
      a = actual(d);
      n_cmp++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL cycle_d%0d t=%0t actual=%h required=%h", d, $time, a, e);
      end
      n_cmp++;
      if ($countones(a.wl) > 1) begin
        n_bad++;
        $display("FAIL onehot_d%0d t=%0t actual=%h required=at most one bit", d, $time, a.wl);
      end
    end
  end

  task automatic check_rec(input string name, input int d, input exp_t e);
    exp_t a;
    a = actual(d);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s actual=%h required=%h", name, a, e);
    end
  endtask

  task automatic issue(input int d, input logic [6:0] ad, input logic w, input bit hold);
    int  start;
    bit  got;
    @(negedge clk);
    valid[d] = 1'b1;
    addr[d]  = ad;
    we[d]    = w;
    start    = acc_cnt[d];
    got      = 1'b0;
    for (int k = 0; k < 60 && !got; k++) begin
      @(negedge clk);
      if (acc_cnt[d] != start) got = 1'b1;
    end
    if (!got) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout_d%0d actual=not accepted required=accepted", d);
    end
    if (!hold) valid[d] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    logic [63:0] exp_wl;
    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b0; valid[d] = 1'b0; addr[d] = '0; we[d] = 1'b0;
      busy_left[d] = 0; acc_cnt[d] = 0;
    end
    repeat (3) @(negedge clk);
    check_rec("reset_d0", 0, IDLE_R);
    check_rec("reset_d1", 1, IDLE_R);
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;
    repeat (5) @(negedge clk);
    check_rec("idle_after_release_d0", 0, IDLE_R);
    check_rec("idle_after_release_d1", 1, IDLE_R);

    issue(0, 7'd37, 1'b0, 1'b0);
    repeat (8) @(negedge clk);

    issue(0, 7'd0, 1'b1, 1'b1);
    issue(0, 7'd63, 1'b1, 1'b0);
    repeat (6) @(negedge clk);

    // New requests while busy must not disturb the latched access.
    issue(0, 7'd20, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      valid[0] = 1'b1;
      addr[0]  = 7'($urandom_range(0, 63));
      we[0]    = 1'($urandom % 2);
      @(negedge clk);
    end
    valid[0] = 1'b0;
    repeat (6) @(negedge clk);

    issue(0, 7'd12, 1'b0, 1'b0);
    @(negedge clk);
    exp_wl = 64'd1 << 12;
    n_cmp++;
    if (wl0 !== exp_wl) begin
      n_bad++;
      $display("FAIL wl_before_reset actual=%h required=%h", wl0, exp_wl);
    end
    rst_n[0] = 1'b0;
    #1;
    check_rec("async_reset_mid_wl", 0, IDLE_R);
    repeat (2) @(negedge clk);
    rst_n[0] = 1'b1;
    repeat (2) @(negedge clk);
    issue(0, 7'd5, 1'b0, 1'b0);
    repeat (8) @(negedge clk);

    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 25; i++) begin
        logic [6:0] ad;
        logic       w;
        bit         hold;
        ad   = 7'($urandom_range(0, (d == 0) ? 63 : 127));
        w    = 1'($urandom % 2);
        hold = 1'($urandom % 2);
        issue(d, ad, w, hold);
        if (!hold) repeat ($urandom % 3) @(negedge clk);
      end
      valid[d] = 1'b0;
      repeat (12) @(negedge clk);
    end

    n_cmp++;
    if (q0.size() != 0 || q1.size() != 0) begin
      n_bad++;
      $display("FAIL drain actual=%0d/%0d pending required=0/0", q0.size(), q1.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
